modbus_rtu_resp_tx: RTL and testbench
=====================================

// Module: modbus_rtu_resp_tx
// PURPOSE
//  Slave-side MODBUS RTU response transmitter for the vending machine. Takes one decoded response
//  request from the command handler, builds the RTU frame (slave id, FC, payload, CRC-16 lo/hi)
//  and serialises it on uart_tx as 8N1, LSB first. Enforces the 3.5-character silent interval
//  before each frame. Sits between the register/dispense logic and the UART TX pin.
// PARAMETERS
//  CLKS_PER_BIT  2604  clk_sys cycles per UART bit (50 MHz / 19200 baud)
//  SILENT_BITS   39    minimum idle-high bit times before a start bit (>= 3.5 chars)
// PORTS
//  clk_sys     in   1   system clock; sole clock of the block
//  rst         in   1   synchronous, active-high reset
//  slave_id    in   8   own slave address, sampled at accept
//  resp_valid  in   1   response request valid
//  resp_ready  out  1   block can accept a request (high only in IDLE)
//  resp_kind   in   2   00 read reply (FC03), 01 write echo (FC06), 1x exception
//  resp_fc     in   8   function code of the request being answered
//  resp_addr   in  16   register address (echo only)
//  resp_data   in  16   register value (read data or echoed value)
//  resp_exc    in   8   exception code (exception only)
//  uart_tx     out  1   serial line, idle high
//  busy        out  1   high from accept until frame_done
//  frame_done  out  1   one-cycle pulse after the last stop bit
// BEHAVIOUR
//  Reset: uart_tx=1, busy=0, frame_done=0, resp_ready=1, state=IDLE, silent counter=0.
//  Accept on rising edge with resp_valid & resp_ready; all resp_* and slave_id latched there;
//   later input changes are ignored until the next accept.
//  Frame bytes (hi byte first for 16-bit fields; CRC lo byte then hi byte):
//   kind 00: id, 0x03, 0x02, data_hi, data_lo, crc_lo, crc_hi             (7 bytes)
//   kind 01: id, 0x06, addr_hi, addr_lo, data_hi, data_lo, crc_lo, crc_hi  (8 bytes)
//   kind 1x: id, resp_fc|0x80, resp_exc, crc_lo, crc_hi                   (5 bytes)
//  CRC: poly 0xA001 reflected, init 0xFFFF, updated once per payload byte when loaded;
//   CRC bytes are not fed back into the CRC.
//  Bit timing: baud counter 0..CLKS_PER_BIT-1; every start/data/stop bit is held exactly
//   CLKS_PER_BIT cycles. No gap between characters inside a frame (stop then next start).
//  Silent counter: counts completed bit times while uart_tx idle-high in IDLE/GAP and
//   saturates at SILENT_BITS; cleared to 0 at the end of each frame and by reset.
//  FSM: IDLE -(accept)-> GAP -(silent>=SILENT_BITS)-> LOAD -> START -> DATA(8 bits)
//   -> STOP -> LOAD if bytes remain, else DONE -> IDLE.
//   GAP passes through in one cycle if the counter is already saturated.
//  Latency with gap satisfied: accept edge N, LOAD at N+1, uart_tx=0 registered at N+2.
//  DONE: frame_done=1 and busy=0 for that single cycle; resp_ready rises the cycle after.
//  Back-to-back: a request accepted right after DONE waits a full SILENT_BITS in GAP.
//  Reset mid-frame: next edge uart_tx=1, IDLE, no frame_done, counter 0, frame discarded.
//  resp_valid held with resp_ready low: no effect, request is not lost (handler holds it).
// TESTING (bench uses CLKS_PER_BIT=4, SILENT_BITS=39; UART monitor decodes uart_tx)
//  1 Reset, id=0x01, kind=00, data=0x0001 -> no start bit before 39 bit times idle, then
//    bytes 01 03 02 00 01 79 84, frame_done pulses once, busy low afterwards.
//  2 kind=01, addr=0x0001, data=0x0003 -> 01 06 00 01 00 03 98 0B; each bit exactly 4 clocks.
//  3 kind=10, fc=0x03, exc=0x02 -> 01 83 02 C0 F1 (5 bytes); fc=0x06, exc=0x02 -> 01 86 02 C3 A1.
//  4 Second request asserted the cycle frame_done pulses -> accepted next cycle; idle-high
//    gap between frames measured >= 39*4 clocks; inputs changed after accept do not alter frame.
//  5 Assert rst during byte 3 -> uart_tx=1 on next edge, busy=0, no frame_done; new request
//    afterwards waits full silent interval and sends a correct frame.
//  6 Gap already elapsed (long idle), accept at edge N -> uart_tx=0 at edge N+2.

Source files
------------

// File: rtl/modbus_rtu_resp_tx.sv
// modbus_rtu_resp_tx
//   Slave-side MODBUS RTU response transmitter. Accepts one decoded response
//   request, builds the RTU frame (slave id, FC, payload, CRC-16 lo/hi) and
//   sends it on uart_tx as 8N1, LSB first. Before each frame it waits until
//   the line has been idle for SILENT_BITS bit times since the last frame.
// Ports
//   clk_sys     system clock
//   rst         synchronous active-high reset
//   slave_id    own slave address, latched at accept
//   resp_valid  response request valid
//   resp_ready  request can be accepted (IDLE only)
//   resp_kind   00 read reply, 01 write echo, 1x exception
//   resp_fc     function code being answered (exception frames)
//   resp_addr   register address (write echo)
//   resp_data   register value (read reply / write echo)
//   resp_exc    exception code
//   uart_tx     serial output, idle high
//   busy        high from accept until frame_done
//   frame_done  one-cycle pulse after the last stop bit
module modbus_rtu_resp_tx #(
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned SILENT_BITS  = 39
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [7:0]  slave_id,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [1:0]  resp_kind,
    input  logic [7:0]  resp_fc,
    input  logic [15:0] resp_addr,
    input  logic [15:0] resp_data,
    input  logic [7:0]  resp_exc,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned SIL_W  = $clog2(SILENT_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [SIL_W-1:0]  SIL_MAX   = SIL_W'(SILENT_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t             state, state_d;
    logic [BAUD_W-1:0]  baud, baud_d;
    logic [SIL_W-1:0]   silent, silent_d;
    logic [2:0]         bit_idx, bit_d;
    logic [7:0]         shreg, shreg_d;
    logic [3:0]         byte_idx, byte_d;
    logic [15:0]        crc, crc_d;
    logic               tx_d;

    logic [7:0]         lat_id, lat_fc, lat_exc;
    logic [1:0]         lat_kind;
    logic [15:0]        lat_addr, lat_data;

    logic [3:0]         pay_len;
    logic [7:0]         pay_byte, load_byte;
    logic               accept, baud_end;

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign accept     = resp_valid && (state == S_IDLE);
    assign baud_end   = (baud == BAUD_LAST);
    assign resp_ready = (state == S_IDLE);
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE) && (state != S_DONE);

    // Payload byte selected by byte_idx from the latched request
    always_comb begin
        pay_byte = lat_id;
        pay_len  = 4'd5;
        if (lat_kind[1]) begin
            pay_len = 4'd3;
            case (byte_idx)
                4'd0:    pay_byte = lat_id;
                4'd1:    pay_byte = lat_fc | 8'h80;
                default: pay_byte = lat_exc;
            endcase
        end else if (lat_kind[0]) begin
            pay_len = 4'd6;
            case (byte_idx)
                4'd0:    pay_byte = lat_id;
                4'd1:    pay_byte = 8'h06;
                4'd2:    pay_byte = lat_addr[15:8];
                4'd3:    pay_byte = lat_addr[7:0];
                4'd4:    pay_byte = lat_data[15:8];
                default: pay_byte = lat_data[7:0];
            endcase
        end else begin
            case (byte_idx)
                4'd0:    pay_byte = lat_id;
                4'd1:    pay_byte = 8'h03;
                4'd2:    pay_byte = 8'h02;
                4'd3:    pay_byte = lat_data[15:8];
                default: pay_byte = lat_data[7:0];
            endcase
        end
        if (byte_idx < pay_len)       load_byte = pay_byte;
        else if (byte_idx == pay_len) load_byte = crc[7:0];
        else                          load_byte = crc[15:8];
    end

    always_comb begin
        state_d  = state;
        baud_d   = baud;
        silent_d = silent;
        bit_d    = bit_idx;
        shreg_d  = shreg;
        byte_d   = byte_idx;
        crc_d    = crc;
        case (state)
            S_IDLE, S_GAP: begin
                baud_d = baud_end ? '0 : baud + BAUD_W'(1);
                if (baud_end && (silent < SIL_MAX)) silent_d = silent + SIL_W'(1);
                if (state == S_IDLE) begin
                    if (accept) begin
                        state_d = S_GAP;
                        byte_d  = '0;
                        crc_d   = '1;
                    end
                end else if (silent >= SIL_MAX) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_d = load_byte;
                if (byte_idx < pay_len) crc_d = crc16_upd(crc, pay_byte);
                byte_d  = byte_idx + 4'd1;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                baud_d = baud_end ? '0 : baud + BAUD_W'(1);
                if (baud_end) state_d = S_DATA;
            end
            S_DATA: begin
                baud_d = baud_end ? '0 : baud + BAUD_W'(1);
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_idx + 3'd1;
                        shreg_d = shreg >> 1;
                    end
                end
            end
            S_STOP: begin
                // Between characters the stop bit ends one cycle early; the
                // LOAD cycle (line still high) completes it, so the next
                // start bit follows with no extra idle time.
                if (byte_idx == pay_len + 4'd2) begin
                    baud_d = baud_end ? '0 : baud + BAUD_W'(1);
                    if (baud_end) state_d = S_DONE;
                end else begin
                    baud_d = (baud == BAUD_PRE) ? '0 : baud + BAUD_W'(1);
                    if (baud == BAUD_PRE) state_d = S_LOAD;
                end
            end
            S_DONE: begin
                silent_d = '0;
                baud_d   = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= S_IDLE;
            baud     <= '0;
            silent   <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            crc      <= '1;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_d;
            baud     <= baud_d;
            silent   <= silent_d;
            bit_idx  <= bit_d;
            shreg    <= shreg_d;
            byte_idx <= byte_d;
            crc      <= crc_d;
            uart_tx  <= tx_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            lat_id   <= '0;
            lat_kind <= '0;
            lat_fc   <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_exc  <= '0;
        end else if (accept) begin
            lat_id   <= slave_id;
            lat_kind <= resp_kind;
            lat_fc   <= resp_fc;
            lat_addr <= resp_addr;
            lat_data <= resp_data;
            lat_exc  <= resp_exc;
        end
    end

endmodule

// File: tb/tb_modbus_rtu_resp_tx.sv
// tb_modbus_rtu_resp_tx
//   Directed bench for modbus_rtu_resp_tx. A frame-level model predicts, from
//   each accepted request, the byte list, the start-bit time and the exact
//   per-cycle line level; a monitor compares DUT outputs every cycle and also
//   decodes the serial bytes for literal frame checks.
module tb_modbus_rtu_resp_tx;

    localparam int CPB     = 4;
    localparam int SIL     = 39;
    localparam int GAP_CYC = CPB * SIL;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  slave_id = 8'h01;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [1:0]  resp_kind = 2'b00;
    logic [7:0]  resp_fc = 8'h00;
    logic [15:0] resp_addr = 16'h0000;
    logic [15:0] resp_data = 16'h0000;
    logic [7:0]  resp_exc = 8'h00;
    logic        uart_tx;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    modbus_rtu_resp_tx #(
        .CLKS_PER_BIT(CPB),
        .SILENT_BITS (SIL)
    ) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .slave_id  (slave_id),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_kind (resp_kind),
        .resp_fc   (resp_fc),
        .resp_addr (resp_addr),
        .resp_data (resp_data),
        .resp_exc  (resp_exc),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Frame model: byte list left-justified (first byte in [63:56]), CRC
    // computed bit-serially over the message.
    function automatic logic [63:0] model_frame(input logic [1:0] kind, input logic [7:0] fc,
                                                input logic [15:0] addr, input logic [15:0] data,
                                                input logic [7:0] exc, input logic [7:0] id,
                                                output int len);
        logic [7:0]  m [0:7];
        logic [15:0] c;
        logic        fb;
        logic [63:0] res;
        int          n;
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        if (kind[1]) begin
            m[0] = id; m[1] = fc | 8'h80; m[2] = exc; n = 3;
        end else if (kind[0]) begin
            m[0] = id; m[1] = 8'h06; m[2] = addr[15:8]; m[3] = addr[7:0];
            m[4] = data[15:8]; m[5] = data[7:0]; n = 6;
        end else begin
            m[0] = id; m[1] = 8'h03; m[2] = 8'h02; m[3] = data[15:8]; m[4] = data[7:0]; n = 5;
        end
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ m[k][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        m[n]     = c[7:0];
        m[n + 1] = c[15:8];
        len = n + 2;
        res = '0;
        for (int k = 0; k < len; k++) res[63 - 8*k -: 8] = m[k];
        return res;
    endfunction

    // Monitor / compare process
    int          mph = 0;      // 0 idle, 1 waiting for start bit, 2 in frame, 3 done cycle
    int          quiet = 0;    // idle cycles since frame end or reset
    int          start_at = 0;
    int          fcnt = 0;
    int          mlen = 0;
    logic [63:0] mbytes = '0;
    logic [7:0]  rx_sh = '0;
    logic [7:0]  rx_q [$];
    int          hi_run = 0;
    int          last_gap = 0;

    always @(negedge clk_sys) begin : mon
        int         ch, pos, ph;
        logic [7:0] cb;
        logic       etx;
        if (rst) begin
            mph = 0;
            quiet = 0;
            hi_run = 0;
        end else begin
            if (mph == 3) begin
                check("done_cycle", 64'({uart_tx, busy, frame_done, resp_ready}), 64'(4'b1010));
                mph = 0;
                quiet = 0;
            end else if (mph == 0) begin
                quiet++;
                check("idle", 64'({uart_tx, busy, frame_done, resp_ready}), 64'(4'b1001));
                if (resp_valid) begin
                    mbytes   = model_frame(resp_kind, resp_fc, resp_addr, resp_data,
                                           resp_exc, slave_id, mlen);
                    start_at = ((quiet + 1 > GAP_CYC + 1) ? quiet + 1 : GAP_CYC + 1) + 2;
                    mph = 1;
                end
            end else begin
                if (mph == 1) begin
                    quiet++;
                    if (quiet == start_at) begin
                        mph = 2;
                        fcnt = 0;
                        last_gap = hi_run;
                    end else begin
                        check("gap", 64'({uart_tx, busy, frame_done, resp_ready}), 64'(4'b1100));
                    end
                end
                if (mph == 2) begin
                    ch  = fcnt / (10 * CPB);
                    pos = (fcnt / CPB) % 10;
                    ph  = fcnt % CPB;
                    cb  = mbytes[63 - 8*ch -: 8];
                    if (pos == 0)      etx = 1'b0;
                    else if (pos == 9) etx = 1'b1;
                    else               etx = cb[pos - 1];
                    check("frame", 64'({uart_tx, busy, frame_done, resp_ready}),
                          64'({etx, 3'b100}));
                    if (ph == CPB / 2) begin
                        if (pos >= 1 && pos <= 8) rx_sh = {uart_tx, rx_sh[7:1]};
                        if (pos == 9) rx_q.push_back(rx_sh);
                    end
                    fcnt++;
                    if (fcnt == mlen * 10 * CPB) mph = 3;
                end
            end
            if (uart_tx) hi_run++;
            else         hi_run = 0;
        end
    end

    task automatic present(input logic [1:0] k, input logic [7:0] fc, input logic [15:0] a,
                           input logic [15:0] d, input logic [7:0] e, input logic [7:0] id);
        @(posedge clk_sys);
        #2;
        resp_kind = k; resp_fc = fc; resp_addr = a; resp_data = d; resp_exc = e;
        slave_id = id; resp_valid = 1'b1;
    endtask

    task automatic wait_accept(output int edge_n);
        int n = 0;
        bit ok = 1'b0;
        edge_n = 0;
        while (!ok && n < 2000) begin
            @(negedge clk_sys);
            n++;
            if (resp_ready) begin
                @(posedge clk_sys);
                #2;
                edge_n = cyc;
                ok = 1'b1;
            end
        end
        check("accept_timeout", 64'(ok), 64'(1));
        resp_valid = 1'b0;
        resp_kind = 2'b01; resp_fc = 8'h5A; resp_addr = 16'hBEEF;
        resp_data = 16'hDEAD; resp_exc = 8'h77; slave_id = 8'hEE;
    endtask

    task automatic wait_done(output int edge_n);
        int n = 0;
        bit ok = 1'b0;
        edge_n = 0;
        while (!ok && n < 3000) begin
            @(negedge clk_sys);
            n++;
            if (frame_done) begin
                ok = 1'b1;
                edge_n = cyc;
            end
        end
        check("done_timeout", 64'(ok), 64'(1));
    endtask

    task automatic check_rx(input string name, input logic [63:0] exp, input int len);
        logic [63:0] got = '0;
        for (int i = 0; i < rx_q.size() && i < 8; i++) got[63 - 8*i -: 8] = rx_q[i];
        check({name, "_len"}, 64'(rx_q.size()), 64'(len));
        check(name, got, exp);
        rx_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : main
        int          ea, ed, ea2, ed2, n, ml;
        logic [63:0] mf;

        // Model pinned against hand-computed frames
        mf = model_frame(2'b00, 8'h03, 16'h0000, 16'h0001, 8'h00, 8'h01, ml);
        check("model_rd", mf, 64'h0103020001798400);
        check("model_rd_len", 64'(ml), 64'(7));
        mf = model_frame(2'b01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h01, ml);
        check("model_wr", mf, 64'h010600010003980B);
        check("model_wr_len", 64'(ml), 64'(8));
        mf = model_frame(2'b10, 8'h03, 16'h0000, 16'h0000, 8'h02, 8'h01, ml);
        check("model_ex3", mf, 64'h018302C0F1000000);
        mf = model_frame(2'b11, 8'h06, 16'h0000, 16'h0000, 8'h02, 8'h01, ml);
        check("model_ex6", mf, 64'h018602C3A1000000);
        check("model_ex6_len", 64'(ml), 64'(5));

        repeat (3) @(posedge clk_sys);
        #2 rst = 1'b0;
        @(negedge clk_sys);
        check("reset_state", 64'({uart_tx, busy, frame_done, resp_ready}), 64'(4'b1001));

        // 1: read reply right after reset, full silent interval first
        present(2'b00, 8'h03, 16'h0000, 16'h0001, 8'h00, 8'h01);
        wait_accept(ea);
        wait_done(ed);
        check_rx("t1_frame", 64'h0103020001798400, 7);
        check("t1_gap", 64'(last_gap >= GAP_CYC), 64'(1));
        @(negedge clk_sys);
        check("t1_busy_after", 64'(busy), 64'(0));

        // 2: write echo
        present(2'b01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h01);
        wait_accept(ea);
        wait_done(ed);
        check_rx("t2_frame", 64'h010600010003980B, 8);

        // 3: exception replies (kind 10 and 11)
        present(2'b10, 8'h03, 16'h0000, 16'h0000, 8'h02, 8'h01);
        wait_accept(ea);
        wait_done(ed);
        check_rx("t3_exc03", 64'h018302C0F1000000, 5);
        present(2'b11, 8'h06, 16'h0000, 16'h0000, 8'h02, 8'h01);
        wait_accept(ea);
        wait_done(ed);
        check_rx("t3_exc06", 64'h018602C3A1000000, 5);

        // 4: second request held pending during frame 1, taken right after DONE
        present(2'b00, 8'h03, 16'h0000, 16'h0001, 8'h00, 8'h01);
        wait_accept(ea);
        present(2'b01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h01);
        wait_done(ed);
        check_rx("t4_frame1", 64'h0103020001798400, 7);
        wait_accept(ea2);
        check("t4_accept_after_done", 64'(ea2 - ed), 64'(2));
        wait_done(ed2);
        check_rx("t4_frame2", 64'h010600010003980B, 8);
        check("t4_gap", 64'(last_gap >= GAP_CYC), 64'(1));

        // 5: reset during byte 3, then a clean frame after a full silent interval
        present(2'b01, 8'h06, 16'h0001, 16'h0003, 8'h00, 8'h01);
        wait_accept(ea);
        n = 0;
        while (rx_q.size() < 2 && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        check("t5_two_bytes", 64'(rx_q.size()), 64'(2));
        repeat (8) @(posedge clk_sys);
        #2 rst = 1'b1;
        @(posedge clk_sys);
        #2 rst = 1'b0;
        @(negedge clk_sys);
        check("t5_after_rst", 64'({uart_tx, busy, frame_done}), 64'(3'b100));
        rx_q.delete();
        present(2'b00, 8'h03, 16'h0000, 16'h0001, 8'h00, 8'h01);
        wait_accept(ea);
        wait_done(ed);
        check_rx("t5_frame", 64'h0103020001798400, 7);
        check("t5_gap", 64'(last_gap >= GAP_CYC), 64'(1));

        // 6: long idle, so the start bit follows the accept by two edges
        repeat (200) @(posedge clk_sys);
        present(2'b11, 8'h06, 16'h0000, 16'h0000, 8'h02, 8'h01);
        wait_accept(ea);
        @(negedge clk_sys);
        check("t6_n1_tx", 64'(uart_tx), 64'(1));
        @(negedge clk_sys);
        check("t6_load_tx", 64'(uart_tx), 64'(1));
        @(negedge clk_sys);
        check("t6_n2_tx", 64'(uart_tx), 64'(0));
        wait_done(ed);
        check_rx("t6_frame", 64'h018602C3A1000000, 5);

        repeat (5) @(posedge clk_sys);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
